gol_engine: RTL and testbench

Parametrised Conway Game-of-Life engine. It is the successor to the fixed 8x8 GOL top and generalises it to a ROWS x COLS grid. It adds selectable toroidal or dead-edge boundaries, direct load, LFSR random fill, and run, step and pause control. It also adds a programmable generation rate, a saturating generation counter, and auto-halt on extinction or still life. It sits between the seed/control logic and the display/readout path.

---
 rtl/gol_engine.sv | 191 +++++++++++++++++++
 tb/tb_gol_engine.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/gol_engine.sv
// ROWS x COLS Game-of-Life engine (rule B3/S23) with load, LFSR fill, run/step/pause control,
// a programmable generation period and auto-halt when the grid is extinct or stable.
module gol_engine #(
   parameter int ROWS   = 8,
   parameter int COLS   = 8,
   parameter int WRAP   = 1,
   parameter int GEN_W  = 16,
   parameter int RATE_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [ROWS*COLS-1:0]   seed,
   input  logic                   load,
   input  logic                   fill,
   input  logic                   start,
   input  logic                   step,
   input  logic                   pause,
   input  logic [RATE_W-1:0]      rate,
   output logic [ROWS*COLS-1:0]   grid_out,
   output logic [GEN_W-1:0]       gen_count,
   output logic [1:0]             state,
   output logic                   extinct,
   output logic                   stable,
   output logic                   busy
);

   localparam int N     = ROWS * COLS;
   localparam int IDX_W = $clog2(N);
   localparam int FC_W  = $clog2(N + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_FILL = 2'b01,
      S_RUN  = 2'b10,
      S_HOLD = 2'b11
   } state_t;

   state_t              state_q, state_d;
   logic [N-1:0]        grid_q, grid_d;
   logic [GEN_W-1:0]    gen_q, gen_d;
   logic [RATE_W-1:0]   tick_q, tick_d;
   logic [31:0]         lfsr_q, lfsr_d;
   logic [FC_W-1:0]     fcnt_q, fcnt_d;
   logic                busy_q, busy_d;
   logic [N-1:0]        next_grid_s;
   logic [GEN_W-1:0]    gen_inc_s;
   logic                extinct_s;
   logic                stable_s;

   // Out-of-range coordinates either wrap around the torus or read as dead cells.
   function automatic logic cell_at(input logic [N-1:0] g, input int r, input int c);
      int  rr;
      int  cc;
      logic v;
      rr = (r + ROWS) % ROWS;
      cc = (c + COLS) % COLS;
      if ((WRAP == 0) && ((r < 0) || (r >= ROWS) || (c < 0) || (c >= COLS))) begin
         v = 1'b0;
      end else begin
         v = g[IDX_W'(rr * COLS + cc)];
      end
      return v;
   endfunction

   function automatic logic [3:0] nbr_count(input logic [N-1:0] g, input int r, input int c);
      logic [3:0] n;
      n = 4'd0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0) || (dc != 0)) begin
               n = n + {3'b000, cell_at(g, r + dr, c + dc)};
            end else begin
               n = n;
            end
         end
      end
      return n;
   endfunction

   // Next generation of every cell, derived purely from the current grid.
   always_comb begin
      next_grid_s = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            next_grid_s[IDX_W'(r * COLS + c)] =
               (nbr_count(grid_q, r, c) == 4'd3) ||
               (grid_q[IDX_W'(r * COLS + c)] && (nbr_count(grid_q, r, c) == 4'd2));
         end
      end
   end

   assign extinct_s = (grid_q == '0);
   assign stable_s  = (next_grid_s == grid_q);
   assign gen_inc_s = (gen_q == {GEN_W{1'b1}}) ? gen_q : (gen_q + {{(GEN_W-1){1'b0}}, 1'b1});

   // Control sequencing; load beats fill beats pause beats start beats step.
   always_comb begin
      state_d = state_q;
      grid_d  = grid_q;
      gen_d   = gen_q;
      tick_d  = tick_q;
      lfsr_d  = lfsr_q;
      fcnt_d  = fcnt_q;
      if (load) begin
         grid_d  = seed;
         gen_d   = '0;
         tick_d  = '0;
         state_d = S_IDLE;
      end else if (fill && (state_q != S_FILL)) begin
         lfsr_d  = (seed[31:0] == 32'h0) ? 32'h1 : seed[31:0];
         gen_d   = '0;
         fcnt_d  = '0;
         state_d = S_FILL;
      end else begin
         case (state_q)
            S_FILL: begin
               grid_d = {grid_q[N-2:0], lfsr_q[0]};
               lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
               if (fcnt_q == FC_W'(N - 1)) begin
                  state_d = S_RUN;
                  tick_d  = '0;
                  fcnt_d  = '0;
               end else begin
                  fcnt_d = fcnt_q + FC_W'(1);
               end
            end
            S_RUN: begin
               if (pause) begin
                  state_d = S_HOLD;
               end else if (tick_q == rate) begin
                  tick_d = '0;
                  if (stable_s || extinct_s) begin
                     state_d = S_HOLD;
                  end else begin
                     grid_d = next_grid_s;
                     gen_d  = gen_inc_s;
                  end
               end else begin
                  tick_d = tick_q + {{(RATE_W-1){1'b0}}, 1'b1};
               end
            end
            S_IDLE, S_HOLD: begin
               if (pause) begin
                  state_d = state_q;
               end else if (start) begin
                  state_d = S_RUN;
                  tick_d  = '0;
               end else if (step && !stable_s) begin
                  grid_d = next_grid_s;
                  gen_d  = gen_inc_s;
               end else begin
                  state_d = state_q;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
      busy_d = (state_d == S_FILL) || (state_d == S_RUN);
   end

   // State, grid and counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         grid_q  <= '0;
         gen_q   <= '0;
         tick_q  <= '0;
         lfsr_q  <= 32'h1;
         fcnt_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grid_q  <= grid_d;
         gen_q   <= gen_d;
         tick_q  <= tick_d;
         lfsr_q  <= lfsr_d;
         fcnt_q  <= fcnt_d;
         busy_q  <= busy_d;
      end
   end

   assign grid_out  = grid_q;
   assign gen_count = gen_q;
   assign state     = state_q;
   assign busy      = busy_q;
   assign extinct   = extinct_s;
   assign stable    = stable_s;

endmodule

// File: tb/tb_gol_engine.sv
// Directed bench for gol_engine: a toroidal 8x8 instance and a dead-edge 8x8 instance with a
// narrow generation counter, driven from a vector table plus hand-written corner sequences.
module tb_gol_engine;

   localparam logic [63:0] BL_H = 64'h0000_0000_1C00_0000;
   localparam logic [63:0] BL_V = 64'h0000_0008_0808_0000;
   localparam logic [63:0] SLIF = 64'h0000_0000_0006_0600;
   localparam logic [63:0] EDGE = 64'h0000_0000_0000_0083;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [63:0] seed = 64'h0;
   logic        load = 1'b0, fill = 1'b0, start = 1'b0, step = 1'b0, pause = 1'b0;
   logic [7:0]  rate = 8'd0;

   logic [63:0] grid1, grid0;
   logic [15:0] gen1;
   logic [2:0]  gen0;
   logic [1:0]  st1, st0;
   logic        ext1, ext0, stb1, stb0, busy1, busy0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gol_engine #(.ROWS(8), .COLS(8), .WRAP(1), .GEN_W(16), .RATE_W(8)) u_wrap (
      .clk(clk), .reset(reset), .seed(seed), .load(load), .fill(fill), .start(start),
      .step(step), .pause(pause), .rate(rate), .grid_out(grid1), .gen_count(gen1),
      .state(st1), .extinct(ext1), .stable(stb1), .busy(busy1)
   );

   gol_engine #(.ROWS(8), .COLS(8), .WRAP(0), .GEN_W(3), .RATE_W(8)) u_dead (
      .clk(clk), .reset(reset), .seed(seed), .load(load), .fill(fill), .start(start),
      .step(step), .pause(pause), .rate(rate), .grid_out(grid0), .gen_count(gen0),
      .state(st0), .extinct(ext0), .stable(stb0), .busy(busy0)
   );

   typedef struct {
      logic [4:0]  ctl;     // load, fill, pause, start, step
      logic [63:0] sd;
      logic [7:0]  rt;
      int          waits;
      logic [63:0] g;
      logic [15:0] gen;
      logic [1:0]  st;
      logic        stb;
   } vec_t;

   vec_t vt[23];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] fill_model(input logic [31:0] s);
      logic [31:0] l;
      logic [63:0] g;
      l = s;
      g = 64'h0;
      for (int k = 0; k < 64; k++) begin
         g = {g[62:0], l[0]};
         l = (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
      end
      return g;
   endfunction

   task automatic fill_count(output int cnt);
      cnt = 0;
      while (busy1 && (st1 == 2'b01) && (cnt < 200)) begin
         cnt++;
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int          cnt;
      logic [63:0] fexp;

      vt[0]  = '{5'b10000, BL_H, 8'd0, 0, BL_H, 16'd0, 2'b00, 1'b0};
      vt[1]  = '{5'b00001, 64'h0, 8'd0, 0, BL_V, 16'd1, 2'b00, 1'b0};
      vt[2]  = '{5'b00001, 64'h0, 8'd0, 0, BL_H, 16'd2, 2'b00, 1'b0};
      vt[3]  = '{5'b10000, SLIF, 8'd0, 0, SLIF, 16'd0, 2'b00, 1'b1};
      vt[4]  = '{5'b00010, 64'h0, 8'd0, 0, SLIF, 16'd0, 2'b10, 1'b1};
      vt[5]  = '{5'b00000, 64'h0, 8'd0, 0, SLIF, 16'd0, 2'b11, 1'b1};
      vt[6]  = '{5'b00001, 64'h0, 8'd0, 0, SLIF, 16'd0, 2'b11, 1'b1};
      vt[7]  = '{5'b10000, BL_H, 8'd3, 0, BL_H, 16'd0, 2'b00, 1'b0};
      vt[8]  = '{5'b00010, 64'h0, 8'd3, 0, BL_H, 16'd0, 2'b10, 1'b0};
      vt[9]  = '{5'b00000, 64'h0, 8'd3, 2, BL_H, 16'd0, 2'b10, 1'b0};
      vt[10] = '{5'b00000, 64'h0, 8'd3, 0, BL_V, 16'd1, 2'b10, 1'b0};
      vt[11] = '{5'b00000, 64'h0, 8'd3, 1, BL_V, 16'd1, 2'b10, 1'b0};
      vt[12] = '{5'b00100, 64'h0, 8'd3, 0, BL_V, 16'd1, 2'b11, 1'b0};
      vt[13] = '{5'b00000, 64'h0, 8'd3, 7, BL_V, 16'd1, 2'b11, 1'b0};
      vt[14] = '{5'b00010, 64'h0, 8'd3, 0, BL_V, 16'd1, 2'b10, 1'b0};
      vt[15] = '{5'b00000, 64'h0, 8'd3, 2, BL_V, 16'd1, 2'b10, 1'b0};
      vt[16] = '{5'b00000, 64'h0, 8'd3, 0, BL_H, 16'd2, 2'b10, 1'b0};
      vt[17] = '{5'b00000, 64'h0, 8'd3, 2, BL_H, 16'd2, 2'b10, 1'b0};
      vt[18] = '{5'b00100, 64'h0, 8'd3, 0, BL_H, 16'd2, 2'b11, 1'b0};
      vt[19] = '{5'b11010, BL_V, 8'd3, 0, BL_V, 16'd0, 2'b00, 1'b0};
      vt[20] = '{5'b00001, 64'h0, 8'd3, 0, BL_H, 16'd1, 2'b00, 1'b0};
      vt[21] = '{5'b00011, 64'h0, 8'd3, 0, BL_H, 16'd1, 2'b10, 1'b0};
      vt[22] = '{5'b00100, 64'h0, 8'd3, 0, BL_H, 16'd1, 2'b11, 1'b0};

      // Reset values while reset is held low
      @(negedge clk);
      chk("rst grid", grid1, 64'h0);
      chk("rst gen", {48'h0, gen1}, 64'h0);
      chk("rst state", {62'h0, st1}, 64'h0);
      chk("rst flags", {61'h0, ext1, stb1, busy1}, 64'h6);
      chk("rst dead grid", grid0, 64'h0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 23; i++) begin
         {load, fill, pause, start, step} = vt[i].ctl;
         seed = vt[i].sd;
         rate = vt[i].rt;
         @(negedge clk);
         {load, fill, pause, start, step} = 5'b00000;
         repeat (vt[i].waits) @(negedge clk);
         chk($sformatf("v%0d grid", i), grid1, vt[i].g);
         chk($sformatf("v%0d gen", i), {48'h0, gen1}, {48'h0, vt[i].gen});
         chk($sformatf("v%0d state", i), {62'h0, st1}, {62'h0, vt[i].st});
         chk($sformatf("v%0d stable", i), {63'h0, stb1}, {63'h0, vt[i].stb});
         chk($sformatf("v%0d busy", i), {63'h0, busy1},
             {63'h0, (vt[i].st == 2'b01) || (vt[i].st == 2'b10)});
      end

      // Edge handling: toroidal vs dead boundary
      seed = EDGE; rate = 8'd0; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk("edge load", grid1, EDGE);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      chk("edge wrap grid", grid1, 64'h0100_0000_0000_0101);
      chk("edge wrap gen", {48'h0, gen1}, 64'h1);
      chk("edge dead grid", grid0, 64'h0);
      chk("edge dead extinct", {63'h0, ext0}, 64'h1);
      chk("edge dead gen", {61'h0, gen0}, 64'h1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("edge dead run", {62'h0, st0}, 64'h2);
      @(negedge clk);
      chk("edge dead halt", {62'h0, st0}, 64'h3);
      chk("edge dead gen2", {61'h0, gen0}, 64'h1);
      chk("edge wrap grid2", grid1, EDGE);
      chk("edge wrap gen2", {48'h0, gen1}, 64'h2);
      chk("edge wrap run", {62'h0, st1}, 64'h2);

      // LFSR fill: zero seed behaves as seed 1; control inputs ignored while filling
      fexp = fill_model(32'h1);
      rate = 8'd255; seed = 64'h0; fill = 1'b1;
      @(negedge clk);
      fill = 1'b0; start = 1'b1; step = 1'b1;
      fill_count(cnt);
      start = 1'b0; step = 1'b0;
      chk("fill0 cycles", 64'(cnt), 64'd64);
      chk("fill0 state", {62'h0, st1}, 64'h2);
      chk("fill0 gen", {48'h0, gen1}, 64'h0);
      chk("fill0 grid", grid1, fexp);
      seed = 64'hFFFF_FFFF_0000_0001; fill = 1'b1;
      @(negedge clk);
      fill = 1'b0;
      fill_count(cnt);
      chk("fill1 cycles", 64'(cnt), 64'd64);
      chk("fill1 grid", grid1, fexp);
      chk("fill1 busy", {63'h0, busy1}, 64'h1);

      // Load aborts a fill in progress
      seed = 64'h1234_5678; fill = 1'b1;
      @(negedge clk);
      fill = 1'b0;
      repeat (10) @(negedge clk);
      chk("abort mid state", {62'h0, st1}, 64'h1);
      seed = SLIF; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk("abort state", {62'h0, st1}, 64'h0);
      chk("abort grid", grid1, SLIF);
      chk("abort busy", {63'h0, busy1}, 64'h0);

      // Saturating counter on the narrow instance while the grid keeps evolving
      seed = BL_H; load = 1'b1; rate = 8'd0;
      @(negedge clk);
      load = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      chk("sat gen", {61'h0, gen0}, 64'h7);
      chk("sat grid", grid0, BL_H);
      chk("run gen", {48'h0, gen1}, 64'd10);
      chk("run grid", grid1, BL_H);
      @(negedge clk);
      chk("sat grid odd", grid0, BL_V);

      // Asynchronous reset mid-run, observed before the next rising edge
      #2;
      reset = 1'b0;
      #1;
      chk("arst grid", grid1, 64'h0);
      chk("arst state", {62'h0, st1}, 64'h0);
      chk("arst gen", {48'h0, gen1}, 64'h0);
      chk("arst flags", {61'h0, ext1, stb1, busy1}, 64'h6);
      chk("arst dead gen", {61'h0, gen0}, 64'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("post rst state", {62'h0, st1}, 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
